// File: rtl/uart_rx_loader.sv
// UART 8N1 receiver with a framed memory-preload parser (0xA5, N, 4N payload bytes -> N words).
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte and expose chk_err.
module uart_rx_loader #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_pin_in,
  input  logic              enable,
  output logic [7:0]        rx_byte,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
`ifdef LOADER_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic              done
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = $clog2(DIV + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_LEN, P_DATA, P_FIN, P_CHK} p_state_t;

  rx_state_t   rx_st;
  p_state_t    p_st;
  logic [1:0]  sync;
  logic        rx_s, rx_prev, tick;
  logic [CW-1:0] tcnt;
  logic [3:0]  os;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  logic [ADDR_W-1:0] n_words, word_cnt, addr;
  logic [1:0]        idx;
  logic [23:0]       word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign rx_s = sync[1];
  assign tick = (tcnt == CW'(DIV - 1));
  assign busy = (p_st != P_IDLE);

  // Byte receiver: oversampled at 16x, start bit re-checked at mid-bit to reject glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= 2'b11;
      rx_prev   <= 1'b1;
      tcnt      <= '0;
      os        <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_st     <= RX_IDLE;
    end else begin
      sync      <= {sync[0], rx_pin_in};
      rx_prev   <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      tcnt      <= tick ? '0 : tcnt + 1'b1;
      case (rx_st)
        RX_IDLE: if (rx_prev && !rx_s) begin
          tcnt  <= '0;
          os    <= '0;
          rx_st <= RX_START;
        end
        RX_START: if (tick) begin
          if (os == 4'd7) begin
            os      <= '0;
            bit_idx <= '0;
            rx_st   <= rx_s ? RX_IDLE : RX_DATA;
          end else os <= os + 1'b1;
        end
        RX_DATA: if (tick) begin
          if (os == 4'd15) begin
            os      <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_st <= RX_STOP;
          end else os <= os + 1'b1;
        end
        RX_STOP: if (tick) begin
          if (os == 4'd15) begin
            os <= '0;
            if (rx_s) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else frame_err <= 1'b1;
            rx_st <= RX_IDLE;
          end else os <= os + 1'b1;
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

  // Packet parser; a framing error or dropped enable abandons the packet without a done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_st     <= P_IDLE;
      n_words  <= '0;
      word_cnt <= '0;
      addr     <= '0;
      idx      <= '0;
      word     <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
      chk_err  <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_err <= 1'b0;
`endif
      if (!enable || frame_err) p_st <= P_IDLE;
      else begin
        case (p_st)
          P_IDLE: if (rx_valid && rx_byte == 8'hA5) p_st <= P_LEN;
          P_LEN: if (rx_valid) begin
            n_words  <= ADDR_W'(rx_byte);
            addr     <= '0;
            idx      <= '0;
            word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            if (ADDR_W'(rx_byte) == '0) begin
              done <= 1'b1;
              p_st <= P_IDLE;
            end else p_st <= P_DATA;
          end
          P_DATA: if (rx_valid) begin
            idx <= idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum <= csum ^ rx_byte;
`endif
            case (idx)
              2'd0: word[7:0]   <= rx_byte;
              2'd1: word[15:8]  <= rx_byte;
              2'd2: word[23:16] <= rx_byte;
              default: begin
                wr_data  <= {rx_byte, word};
                wr_addr  <= addr;
                wr_en    <= 1'b1;
                addr     <= addr + 1'b1;
                word_cnt <= word_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                if (word_cnt == n_words - 1'b1) p_st <= P_CHK;
`else
                if (word_cnt == n_words - 1'b1) p_st <= P_FIN;
`endif
              end
            endcase
          end
          P_FIN: begin
            done <= 1'b1;
            p_st <= P_IDLE;
          end
`ifdef LOADER_CHECKSUM_EN
          P_CHK: if (rx_valid) begin
            if (rx_byte == csum) done <= 1'b1;
            else chk_err <= 1'b1;
            p_st <= P_IDLE;
          end
`endif
          default: p_st <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader at 16 MHz / 100 kbaud (160 clk per bit).
module tb_uart_rx_loader;
  logic        clk = 1'b0, reset = 1'b1, rx = 1'b1, enable = 1'b1;
  logic [7:0]  rx_byte;
  logic        rx_valid, frame_err, wr_en, busy, done;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
`ifdef LOADER_CHECKSUM_EN
  logic        chk_err;
  int          nchk = 0;
`endif

  int errors = 0, checks = 0;
  int nvalid = 0, nfe = 0, nwr = 0, ndone = 0, nboth = 0;
  logic [7:0]  last_byte = '0;
  logic [7:0]  wa [0:15];
  logic [31:0] wd [0:15];

  uart_rx_loader #(.CLK_HZ(16000000), .BAUD(100000), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .rx_pin_in(rx), .enable(enable),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
`ifdef LOADER_CHECKSUM_EN
    .chk_err(chk_err),
`endif
    .done(done));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin nvalid++; last_byte = rx_byte; end
    if (frame_err) nfe++;
    if (rx_valid && frame_err) nboth++;
    if (done) ndone++;
`ifdef LOADER_CHECKSUM_EN
    if (chk_err) nchk++;
`endif
    if (wr_en && nwr < 16) begin wa[nwr] = wr_addr; wd[nwr] = wr_data; nwr++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0; repeat (160) @(negedge clk);
    for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (160) @(negedge clk); end
    rx = stop; repeat (160) @(negedge clk);
    rx = 1'b1; repeat (20) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".rx_byte"}, 32'(rx_byte), 32'h0);
    chk({tag, ".strobes"}, {27'h0, rx_valid, frame_err, wr_en, done, busy}, 32'h0);
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'h0);
    chk({tag, ".wr_data"}, wr_data, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    chk("reset.rx_state", 32'(int'(dut.rx_st)), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // single byte, parser idle
    send_byte(8'h3C);
    chk("byte.count", 32'(nvalid), 32'd1);
    chk("byte.value", 32'(rx_byte), 32'h3C);
    chk("byte.fe", 32'(nfe), 32'd0);

    // two-word packet
    send_byte(8'hA5);
    send_byte(8'h02);
    chk("pkt.busy_mid", 32'(busy), 32'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h88);
`endif
    chk("pkt.nwr", 32'(nwr), 32'd2);
    chk("pkt.addr0", 32'(wa[0]), 32'd0);
    chk("pkt.data0", wd[0], 32'h44332211);
    chk("pkt.addr1", 32'(wa[1]), 32'd1);
    chk("pkt.data1", wd[1], 32'h88776655);
    chk("pkt.done", 32'(ndone), 32'd1);
    chk("pkt.busy_end", 32'(busy), 32'd0);
    chk("pkt.hold_addr", 32'(wr_addr), 32'd1);
    chk("pkt.hold_data", wr_data, 32'h88776655);

    // 4-clk glitch then a real byte
    rx = 1'b0; repeat (4) @(negedge clk); rx = 1'b1;
    repeat (400) @(negedge clk);
    chk("glitch.valid", 32'(nvalid), 32'd11 + 32'(`ifdef LOADER_CHECKSUM_EN 1 `else 0 `endif));
    chk("glitch.fe", 32'(nfe), 32'd0);
    chk("glitch.rx_state", 32'(int'(dut.rx_st)), 32'd0);
    send_byte(8'h5A);
    chk("after_glitch.byte", 32'(last_byte), 32'h5A);

    // framing error mid-packet
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hDE);
    chk("fe.busy_before", 32'(busy), 32'd1);
    send_byte(8'h00, 1'b0);
    chk("fe.count", 32'(nfe), 32'd1);
    chk("fe.nwr", 32'(nwr), 32'd2);
    chk("fe.busy", 32'(busy), 32'd0);
    chk("fe.rx_byte_kept", 32'(rx_byte), 32'hDE);
    chk("fe.done", 32'(ndone), 32'd1);

    // zero-length packet
    send_byte(8'hA5); send_byte(8'h00);
    chk("n0.done", 32'(ndone), 32'd2);
    chk("n0.nwr", 32'(nwr), 32'd2);
    chk("n0.busy", 32'(busy), 32'd0);

    // loader disabled
    enable = 1'b0;
    send_byte(8'hA5);
    chk("dis.busy", 32'(busy), 32'd0);
    send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    chk("dis.nwr", 32'(nwr), 32'd2);
    chk("dis.byte", 32'(rx_byte), 32'hDD);
    enable = 1'b1;

    // reset after two payload bytes
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (5) @(negedge clk);
    reset = 1'b0;
    send_byte(8'h33); send_byte(8'h44);
    chk("midreset.nwr", 32'(nwr), 32'd2);
    chk("midreset.busy", 32'(busy), 32'd0);
    chk("both_pulses", 32'(nboth), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0F);
    chk("cs_ok.nwr", 32'(nwr), 32'd3);
    chk("cs_ok.data", wd[2], 32'h08040201);
    chk("cs_ok.done", 32'(ndone), 32'd3);
    chk("cs_ok.chk_err", 32'(nchk), 32'd0);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h00);
    chk("cs_bad.nwr", 32'(nwr), 32'd4);
    chk("cs_bad.chk_err", 32'(nchk), 32'd1);
    chk("cs_bad.done", 32'(ndone), 32'd3);
    chk("cs_bad.busy", 32'(busy), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_loader.md
Name: uart_rx_loader

Overview:
Host-to-board UART receive path. It deserialises 8N1 bytes from the rx pin, parses a framed load packet (sync byte, word count, payload), and emits little-endian 32-bit write strobes with an auto-incrementing address. Its output feeds instruction/data memory preload while the core is held off. It is the receiving counterpart to the board's debug-dump transmit path.

Parameters:
CLK_HZ, 100000000, system clock frequency.
BAUD, 115200, line rate.
ADDR_W, 8, width of the word address and the word count.
- Derived constant DIV = CLK_HZ/(BAUD*16), integer truncation, minimum 1: the 16x oversample tick period in clk cycles.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high.
rx_pin_in  input  1  serial line, idle high, asynchronous to clk.
enable  input  1  when 0, the loader ignores received bytes and the parser is held in IDLE; the byte receiver keeps running.
rx_byte  output  8  last correctly framed byte.
rx_valid  output  1  one-cycle pulse when rx_byte updates.
frame_err  output  1  one-cycle pulse when the stop bit is sampled as 0.
wr_en  output  1  one-cycle word write strobe.
wr_addr  output  ADDR_W  word address for wr_data.
wr_data  output  32  assembled word.
busy  output  1  high while the parser is in any state other than IDLE.
done  output  1  one-cycle pulse after the last word of a packet is written.

Behaviour:
- Reset values: all outputs are 0. Internal byte receiver is in RX_IDLE, parser is in IDLE, synchroniser flops are 1, and all counters are 0.
- Synchroniser: rx_pin_in passes through 2 flops. All logic uses only the synchronised value.
- Tick generator: free-running counter of DIV; issues a one-cycle tick at terminal count.
- Byte receiver FSM: RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE.
- RX_IDLE: on a synchronised 1->0 edge, clear the tick counter and the oversample count, then go to RX_START.
- RX_START: at oversample count 7 (mid-bit), a line value of 1 is a glitch; return to RX_IDLE with no pulse. A value of 0 proceeds.
- RX_DATA: sample every 16 ticks, LSB first, 8 bits.
- RX_STOP: sample at mid-bit. A value of 1 updates rx_byte and pulses rx_valid. A value of 0 pulses frame_err, leaves rx_byte unchanged, and aborts the parser to IDLE.
- rx_valid and frame_err assert on the clk cycle after the stop sample and never both in the same cycle.
- Parser FSM (advances only on rx_valid while enable=1):
  - IDLE: byte 0xA5 -> LEN. Any other byte is ignored.
  - LEN: latch N = byte. N=0 -> pulse done, go to IDLE. Otherwise clear the address and byte index, go to DATA.
  - DATA: shift the byte into lane (index): byte0 -> [7:0] … byte3 -> [31:24]. On the 4th byte, wr_data and wr_en are valid for exactly one cycle, with wr_addr = current address.
    - Address then increments, wrapping modulo 2^ADDR_W.
    - After the Nth word: without checksum, pulse done in the cycle after the last wr_en and go to IDLE. With checksum, go to CHK.
- wr_addr and wr_data hold their values between strobes.
- enable dropping mid-packet forces the parser to IDLE on the next clock. No further wr_en is issued, and no done.
- A new 0xA5 in DATA is treated as payload, not resync.
- Asynchronous reset mid-byte or mid-packet immediately returns everything to reset values. No partial word is written.

Optional Feature:
LOADER_CHECKSUM_EN. When defined:
- The parser adds a CHK state and an output chk_err (1 bit, reset 0).
- The packet carries one extra byte after the payload, equal to the XOR of all 4N payload bytes.
- On match, done pulses. On mismatch, chk_err pulses instead of done, and the already-written words remain.
- Either way the parser returns to IDLE.
When undefined: no CHK state, no chk_err port, and done follows the last word directly.

Test Plan:
- CLK_HZ=16000000, BAUD=100000 (DIV=10, 160 clk/bit). Send byte 0x3C -> rx_byte=0x3C with a single rx_valid pulse, frame_err=0.
- Send 0xA5, 0x02, then bytes 11 22 33 44 55 66 77 88 -> wr_en at addr 0 with data 0x44332211, then at addr 1 with 0x88776655. Then done pulses once and busy returns to 0.
- Hold rx low for 4 clk and release (glitch) -> no rx_valid, no frame_err, FSM back in RX_IDLE. A following 0x5A is received correctly.
- Send 0xA5, 0x01, 0xDE, then a byte with stop bit 0 -> frame_err pulses, no wr_en, and parser in IDLE (busy=0).
- Set enable=0 and send 0xA5 0x01 AA BB CC DD -> no wr_en and busy stays 0. Also: assert reset after 2 payload bytes of a valid packet -> all outputs return to 0 and no wr_en.
- With LOADER_CHECKSUM_EN: 0xA5 0x01 01 02 04 08 0x0F -> wr_data 0x08040201 and done. The same packet with checksum 0x00 -> chk_err pulses and done stays 0.
